// File: rtl/add16_arbiter.sv
`timescale 1ns/1ps
// add16_arbiter
// Shares one 16-bit adder between NUM_REQ requesters. A round-robin arbiter
// grants one request per IDLE cycle, latches its operands and owner ID, adds
// them in the CALC cycle, and holds a registered result in RESP until the
// consumer takes it.
//
// Ports:
//   clk        system clock, all state moves on the rising edge
//   rst_n      synchronous active-low reset
//   req_valid  per-requester request valid (bit i = requester i)
//   req_a      packed operand A, requester i at [16*i+15:16*i]
//   req_b      packed operand B, same packing as req_a
//   req_ready  one-hot combinational grant, zero outside IDLE and in reset
//   rsp_valid  registered result valid
//   rsp_ready  consumer accepts the result
//   rsp_sum    registered a+b mod 2^16
//   rsp_id     index of the requester that owns rsp_sum
//   rsp_ovf    two's-complement overflow of a+b
module add16_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [15:0]             rsp_sum,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   id_r;
    logic [15:0]       op_a_r;
    logic [15:0]       op_b_r;
    logic [15:0]       sum_s;
    logic [ID_W:0]     pick_s;
    logic              found_s;
    logic [ID_W-1:0]   gnt_idx_s;

    // Round-robin search starting at ptr; returns {found, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic            found;
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] res;
        found = 1'b0;
        res   = {ID_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && valid[idx]) begin
                found = 1'b1;
                res   = idx;
            end else begin
                found = found;
            end
        end
        return {found, res};
    endfunction

    // Signed overflow: operands agree in sign but the sum does not.
    function automatic logic add_ovf(input logic [15:0] a,
                                     input logic [15:0] b,
                                     input logic [15:0] s);
        return (a[15] == b[15]) && (s[15] != a[15]);
    endfunction

    // Arbitration result and the single shared adder.
    always_comb begin
        pick_s    = rr_pick(req_valid, ptr_r);
        found_s   = pick_s[ID_W];
        gnt_idx_s = pick_s[ID_W-1:0];
        sum_s     = op_a_r + op_b_r;
    end

    // One-hot grant, only offered from IDLE and never while in reset.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (rst_n && (state_r == IDLE) && found_s) begin
            req_ready[gnt_idx_s] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nx_s = CALC;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CALC: state_nx_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand capture, pointer advance and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r     <= {ID_W{1'b0}};
            id_r      <= {ID_W{1'b0}};
            op_a_r    <= 16'h0000;
            op_b_r    <= 16'h0000;
            rsp_valid <= 1'b0;
            rsp_sum   <= 16'h0000;
            rsp_id    <= {ID_W{1'b0}};
            rsp_ovf   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        op_a_r <= req_a[16*gnt_idx_s +: 16];
                        op_b_r <= req_b[16*gnt_idx_s +: 16];
                        id_r   <= gnt_idx_s;
                        // ptr only moves on a grant, wrapping at NUM_REQ.
                        ptr_r  <= (gnt_idx_s == ID_W'(NUM_REQ - 1)) ?
                                  {ID_W{1'b0}} : gnt_idx_s + ID_W'(1);
                    end
                end
                CALC: begin
                    rsp_sum   <= sum_s;
                    rsp_id    <= id_r;
                    rsp_ovf   <= add_ovf(op_a_r, op_b_r, sum_s);
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add16_arbiter.sv
`timescale 1ns/1ps
// Directed self-checking bench for add16_arbiter (NUM_REQ = 4).
module tb_add16_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_sum;
    logic [1:0]  rsp_id;
    logic        rsp_ovf;

    int total;
    int bad;

    add16_arbiter #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    // Single request from one requester with rsp_ready high; starts and ends
    // at a negedge while the DUT is in IDLE.
    task automatic do_one(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] es, input logic eo);
        logic [3:0] oh;
        oh = 4'b0001 << i;
        set_ops(i, a, b);
        req_valid = oh;
        #1;
        chk("one_grant", 32'(req_ready), 32'(oh));
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("one_calc_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("one_valid", 32'(rsp_valid), 32'd1);
        chk("one_sum", 32'(rsp_sum), 32'(es));
        chk("one_id", 32'(rsp_id), i);
        chk("one_ovf", 32'(rsp_ovf), 32'(eo));
        @(negedge clk);
        chk("one_drop", 32'(rsp_valid), 32'd0);
    endtask

    logic [15:0] a_tab [4];
    logic [15:0] b_tab [4];
    logic [15:0] s_tab [4];
    logic        o_tab [4];

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_a     = 64'h0;
        req_b     = 64'h0;
        rsp_ready = 1'b1;

        a_tab = '{16'h1111, 16'h2222, 16'h7000, 16'hF000};
        b_tab = '{16'h0001, 16'h1000, 16'h1000, 16'h2000};
        s_tab = '{16'h1112, 16'h3222, 16'h8000, 16'h1000};
        o_tab = '{1'b0,     1'b0,     1'b1,     1'b0};

        // 1. reset with everyone requesting
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_valid", 32'(rsp_valid), 32'd0);
            chk("rst_sum", 32'(rsp_sum), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(req_ready), 32'h1);
        req_valid = 4'b0000;

        // 2. single request
        do_one(2, 16'h1234, 16'h0F0F, 16'h2143, 1'b0);
        // 3. wrap and overflow
        do_one(0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
        do_one(1, 16'h7FFF, 16'h0001, 16'h8000, 1'b1);
        do_one(3, 16'h8000, 16'h8000, 16'h0000, 1'b1);

        // 4. round-robin, all valid, ptr back at 0; grants every 3 cycles
        for (int i = 0; i < 4; i++) set_ops(i, a_tab[i], b_tab[i]);
        req_valid = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (g % 4)));
            @(negedge clk);
            chk("rr_calc_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), g % 4);
            chk("rr_sum", 32'(rsp_sum), 32'(s_tab[g % 4]));
            chk("rr_ovf", 32'(rsp_ovf), 32'(o_tab[g % 4]));
            chk("rr_resp_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 4'b0000;
        #1;
        chk("rr_idle_valid", 32'(rsp_valid), 32'd0);

        // 5. backpressure; ptr=2 so requester 3 wins, then requester 1
        rsp_ready = 1'b0;
        set_ops(1, 16'h4000, 16'h4000);
        set_ops(3, 16'h0102, 16'h0304);
        req_valid = 4'b1010;
        #1;
        chk("bp_grant3", 32'(req_ready), 32'b1000);
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_sum", 32'(rsp_sum), 32'h0406);
            chk("bp_id", 32'(rsp_id), 32'd3);
            chk("bp_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_grant1", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("bp2_sum", 32'(rsp_sum), 32'h8000);
        chk("bp2_id", 32'(rsp_id), 32'd1);
        chk("bp2_ovf", 32'(rsp_ovf), 32'd1);
        @(negedge clk);
        chk("bp2_drop", 32'(rsp_valid), 32'd0);

        // 6. reset during CALC; ptr is 2 here
        set_ops(2, 16'h0005, 16'h0006);
        req_valid = 4'b0100;
        #1;
        chk("mr_grant", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        req_valid = 4'b1111;
        #1;
        chk("mr_restart", 32'(req_ready), 32'b0001);
        chk("mr_sum", 32'(rsp_sum), 32'd0);
        req_valid = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
